// File: rtl/irq_pkg.sv
// irq_pkg: shared state encoding, default widths and vector address helper.
package irq_pkg;
  typedef enum logic {IDLE, IN_ISR} irq_state_e;
  localparam int PC_W_DEFAULT = 23;
  function automatic logic [31:0] vec_addr(input logic [31:0] base, input logic [31:0] idx);
    return base + (idx << 2);
  endfunction
endpackage

// File: rtl/irq_sync_edge.sv
// irq_sync_edge: two-flop synchroniser followed by a rising-edge detector.
module irq_sync_edge (
  input  logic clk,
  input  logic reset,
  input  logic irq_i,
  output logic rise_o
);
  logic s1_q, s2_q, prev_q;
  logic s1_d, s2_d, prev_d;
  always_comb begin
    s1_d   = irq_i;
    s2_d   = s1_q;
    prev_d = s2_q;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_q   <= 1'b0;
      s2_q   <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      s1_q   <= s1_d;
      s2_q   <= s2_d;
      prev_q <= prev_d;
    end
  end
  assign rise_o = s2_q & ~prev_q;
endmodule

// File: rtl/irq_sequencer.sv
// irq_sequencer: latches interrupt edges, picks the lowest enabled pending source
// at an instruction boundary and tracks the single-level handler state.
module irq_sequencer
  import irq_pkg::*;
#(
  parameter int              NUM_IRQ     = 4,
  parameter int              PC_W        = PC_W_DEFAULT,
  parameter logic [PC_W-1:0] VECTOR_BASE = PC_W'('h100),
  localparam int             SEL_W       = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_IRQ-1:0] irq_i,
  input  logic [NUM_IRQ-1:0] irq_en,
  input  logic               gie,
  input  logic               pcflag,
  input  logic               mret,
  input  logic [PC_W-1:0]    pc_resume,
  output logic               interrupt,
  output logic [PC_W-1:0]    isr_target,
  output logic [PC_W-1:0]    isr_return,
  output logic               in_isr,
  output logic [SEL_W-1:0]   irq_cause,
  output logic [NUM_IRQ-1:0] pending
);
  irq_state_e         state_q, state_d;
  logic [PC_W-1:0]    isr_return_q, isr_return_d;
  logic [SEL_W-1:0]   irq_cause_q, irq_cause_d;
  logic [NUM_IRQ-1:0] pending_q, pending_d;
  logic [NUM_IRQ-1:0] rise, eligible, clr;
  logic [SEL_W-1:0]   sel;
  logic               take;
  for (genvar i = 0; i < NUM_IRQ; i++) begin : g_sync
    irq_sync_edge u_sync (
      .clk    (clk),
      .reset  (reset),
      .irq_i  (irq_i[i]),
      .rise_o (rise[i])
    );
  end
  assign eligible = pending_q & irq_en;
  always_comb begin
    sel = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--)
      if (eligible[i]) sel = SEL_W'(i);
  end
  // A fresh edge landing on the acceptance edge re-arms the source: set beats clear.
  always_comb begin
    take         = (state_q == IDLE) && pcflag && gie && |eligible;
    clr          = take ? (NUM_IRQ'(1) << sel) : '0;
    pending_d    = (pending_q & ~clr) | rise;
    state_d      = take ? IN_ISR : ((state_q == IN_ISR) && pcflag && mret) ? IDLE : state_q;
    isr_return_d = take ? pc_resume : isr_return_q;
    irq_cause_d  = take ? sel : irq_cause_q;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      isr_return_q <= '0;
      irq_cause_q  <= '0;
      pending_q    <= '0;
    end else begin
      state_q      <= state_d;
      isr_return_q <= isr_return_d;
      irq_cause_q  <= irq_cause_d;
      pending_q    <= pending_d;
    end
  end
  assign interrupt  = take;
  assign isr_target = PC_W'(vec_addr(32'(VECTOR_BASE), 32'(sel)));
  assign isr_return = isr_return_q;
  assign irq_cause  = irq_cause_q;
  assign in_isr     = (state_q == IN_ISR);
  assign pending    = pending_q;
endmodule

// File: tb/tb_irq_sequencer.sv
// tb_irq_sequencer: directed scoreboard bench for irq_sequencer.
module tb_irq_sequencer;
  typedef struct {
    logic        intr;
    logic [22:0] tgt;
    logic [22:0] ret;
    logic [1:0]  cause;
    logic        inisr;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  irq_i = '0;
  logic [3:0]  irq_en = '0;
  logic        gie = 1'b0;
  logic        pcflag = 1'b0;
  logic        mret = 1'b0;
  logic [22:0] pc_resume = '0;
  logic        interrupt;
  logic [22:0] isr_target;
  logic [22:0] isr_return;
  logic        in_isr;
  logic [1:0]  irq_cause;
  logic [3:0]  pending;

  exp_t        exp_q[$];
  int          vectors = 0;
  int          errs = 0;
  logic [22:0] m_ret = '0;
  logic [1:0]  m_cause = '0;
  logic        m_in = 1'b0;

  irq_sequencer dut (
    .clk        (clk),
    .reset      (rst),
    .irq_i      (irq_i),
    .irq_en     (irq_en),
    .gie        (gie),
    .pcflag     (pcflag),
    .mret       (mret),
    .pc_resume  (pc_resume),
    .interrupt  (interrupt),
    .isr_target (isr_target),
    .isr_return (isr_return),
    .in_isr     (in_isr),
    .irq_cause  (irq_cause),
    .pending    (pending)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic tick(input int n);
    for (int k = 0; k < n; k++) @(negedge clk);
  endtask

  // Lines driven just before this call are visible in pending after the third edge.
  task automatic wait_pend(input string tag, input logic [3:0] early, input logic [3:0] late);
    tick(2);
    chk({tag, "_pend2"}, 32'(pending), 32'(early));
    tick(1);
    chk({tag, "_pend3"}, 32'(pending), 32'(late));
  endtask

  task automatic boundary(input logic m, input logic [22:0] pcr, input logic ei, input int src);
    exp_t       e;
    logic       int_s;
    logic [22:0] tgt_s;
    pcflag    = 1'b1;
    mret      = m;
    pc_resume = pcr;
    if (ei) begin
      m_ret   = pcr;
      m_cause = 2'(src);
      m_in    = 1'b1;
    end else if (m && m_in) begin
      m_in = 1'b0;
    end
    exp_q.push_back('{ei, 23'h000100 + 23'(src << 2), m_ret, m_cause, m_in});
    #1;
    int_s = interrupt;
    tgt_s = isr_target;
    @(negedge clk);
    pcflag = 1'b0;
    mret   = 1'b0;
    e = exp_q.pop_front();
    chk("interrupt", 32'(int_s), 32'(e.intr));
    if (e.intr) chk("isr_target", 32'(tgt_s), 32'(e.tgt));
    chk("isr_return", 32'(isr_return), 32'(e.ret));
    chk("irq_cause", 32'(irq_cause), 32'(e.cause));
    chk("in_isr", 32'(in_isr), 32'(e.inisr));
  endtask

  initial begin
    tick(2);
    chk("rst_pending", 32'(pending), 0);
    chk("rst_in_isr", 32'(in_isr), 0);
    chk("rst_return", 32'(isr_return), 0);
    chk("rst_cause", 32'(irq_cause), 0);
    chk("rst_interrupt", 32'(interrupt), 0);
    rst = 1'b0;

    gie = 1'b1;
    irq_en = 4'b0100;
    irq_i[2] = 1'b1;
    wait_pend("single", 4'b0000, 4'b0100);
    irq_i[2] = 1'b0;
    boundary(1'b0, 23'h000040, 1'b1, 2);
    chk("single_clr", 32'(pending), 0);
    boundary(1'b1, 23'h000200, 1'b0, 0);

    irq_en = 4'b1111;
    irq_i[3] = 1'b1;
    irq_i[1] = 1'b1;
    wait_pend("prio", 4'b0000, 4'b1010);
    boundary(1'b0, 23'h000050, 1'b1, 1);
    boundary(1'b0, 23'h000060, 1'b0, 0);
    boundary(1'b1, 23'h000064, 1'b0, 0);
    boundary(1'b0, 23'h000070, 1'b1, 3);
    boundary(1'b1, 23'h000074, 1'b0, 0);
    irq_i = '0;

    gie = 1'b0;
    irq_i[0] = 1'b1;
    wait_pend("mask", 4'b0000, 4'b0001);
    for (int i = 0; i < 10; i++) boundary(1'b0, 23'h000080 + 23'(i), 1'b0, 0);
    chk("mask_hold", 32'(pending), 32'(4'b0001));
    gie = 1'b1;
    boundary(1'b0, 23'h000090, 1'b1, 0);

    irq_i[0] = 1'b0;
    irq_i[1] = 1'b1;
    wait_pend("nest", 4'b0000, 4'b0010);
    boundary(1'b0, 23'h000094, 1'b0, 0);
    boundary(1'b1, 23'h000098, 1'b0, 0);
    boundary(1'b0, 23'h00009C, 1'b1, 1);
    boundary(1'b1, 23'h0000A0, 1'b0, 0);
    irq_i[1] = 1'b0;
    tick(4);

    // Second rise of source 0 reaches the detector exactly on the acceptance edge.
    irq_i[0] = 1'b1;
    tick(1);
    irq_i[0] = 1'b0;
    tick(1);
    irq_i[0] = 1'b1;
    tick(1);
    chk("coll_pend", 32'(pending), 32'(4'b0001));
    tick(1);
    boundary(1'b0, 23'h0000A0, 1'b1, 0);
    chk("coll_setwins", 32'(pending), 32'(4'b0001));
    boundary(1'b1, 23'h0000A4, 1'b0, 0);
    boundary(1'b0, 23'h0000A8, 1'b1, 0);
    boundary(1'b1, 23'h0000AC, 1'b0, 0);
    chk("coll_done", 32'(pending), 0);
    irq_i[0] = 1'b0;

    irq_i[2] = 1'b1;
    irq_i[3] = 1'b1;
    wait_pend("arst", 4'b0000, 4'b1100);
    boundary(1'b0, 23'h0000B0, 1'b1, 2);
    irq_i[2] = 1'b0;
    chk("arst_pre", 32'(pending), 32'(4'b1000));
    #3 rst = 1'b1;
    m_ret = '0;
    m_cause = '0;
    m_in = 1'b0;
    #1;
    chk("arst_in_isr", 32'(in_isr), 0);
    chk("arst_pending", 32'(pending), 0);
    chk("arst_return", 32'(isr_return), 0);
    tick(2);
    rst = 1'b0;
    wait_pend("held", 4'b0000, 4'b1000);
    boundary(1'b0, 23'h0000C0, 1'b1, 3);
    tick(5);
    chk("held_once", 32'(pending), 0);
    boundary(1'b1, 23'h0000C4, 1'b0, 0);
    irq_i = '0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule

// File: doc/irq_sequencer.md
# irq_sequencer

Interrupt sequencer for the TinyWhisper RV core's program-counter unit. It synchronises and latches external interrupt edges, applies per-source and global enables, and picks the highest-priority pending source. At an instruction boundary it produces the interrupt strobe, vector target and saved return address consumed by the instruction counter. It tracks the single-level in-handler state until MRET retires.

## Interface
- NUM_IRQ, default 4: number of interrupt sources (1..8).
- PC_W, default 23: program-counter width.
- VECTOR_BASE, default 23'h000100: vector table base; entry spacing is 4 bytes.
- clk  in  1  core clock; all state on rising edge.
- reset  in  1  asynchronous, active-high reset; one clock domain.
- irq_i  in  NUM_IRQ  raw asynchronous interrupt lines; rising edge requests.
- irq_en  in  NUM_IRQ  per-source enable mask.
- gie  in  1  global interrupt enable.
- pcflag  in  1  instruction-boundary strobe (PC update cycle).
- mret  in  1  MRET retiring; valid only with pcflag.
- pc_resume  in  PC_W  address the PC would load this cycle without an interrupt.
- interrupt  out  1  take-interrupt strobe to the instruction counter.
- isr_target  out  PC_W  vector address of the selected source.
- isr_return  out  PC_W  saved resume address (MRET target).
- in_isr  out  1  handler active.
- irq_cause  out  $clog2(NUM_IRQ) (min 1)  index of the last taken source.
- pending  out  NUM_IRQ  latched pending bits.

## Operation
- Per source: 2-flop synchroniser, then a rising-edge detector against the previous synchronised value. A detected edge sets pending[i].
- Selection: eligible = pending & irq_en; the lowest index wins.
- isr_target = VECTOR_BASE + {sel, 2'b00}, truncated to PC_W; wraps modulo 2^PC_W.
- The state machine has two states: IDLE and IN_ISR.
- IDLE: interrupt = pcflag & gie & |eligible (combinational from registered state and inputs). When interrupt=1, on the same edge:
  - isr_return <= pc_resume
  - irq_cause <= sel
  - pending[sel] <= 0
  - state goes to IN_ISR.
- IN_ISR: interrupt is forced 0 (no nesting). When pcflag & mret, state goes to IDLE.
- mret in IDLE is ignored; isr_return holds.
- Pending bits accumulate while masked, while gie=0, and while in IN_ISR. They are never lost.
- in_isr = (state == IN_ISR).

## Timing
- Reset values:
  - state IDLE
  - all sync/edge flops 0
  - pending 0
  - isr_return 0
  - irq_cause 0
  - interrupt 0
  - in_isr 0
- Because sync flops reset to 0, a line held high through reset produces one edge after reset deasserts.
- irq_i rise to pending set: 3 clk edges (two sync flops plus edge register). The earliest interrupt strobe is in the cycle after pending is visible, qualified by pcflag.
- interrupt is valid in the same cycle as pcflag. The PC loads isr_target on that edge. isr_return and in_isr update on that same edge.
- The first handler instruction boundary can take MRET. After MRET, IDLE may take the next pending source at the very next pcflag (tail-chaining, zero idle cycles).
- Simultaneous events:
  - New edge on a source in the same cycle its bit is cleared by acceptance: set wins, so pending stays 1.
  - Edges on several sources in one cycle: all latch; the lowest index is served first.
- Reset mid-handler: returns to IDLE immediately (asynchronous) and discards pending bits.
- pcflag=0: no state change other than pending accumulation.

## Structure
- Package irq_pkg holds:
  - typedef irq_state_e {IDLE, IN_ISR}
  - localparam PC_W_DEFAULT = 23
  - function vec_addr(base, idx) computing the vector target.
- One sub-module, irq_sync_edge: per-source 2-flop synchroniser plus rising-edge detect, instantiated NUM_IRQ times via generate.
- The priority encoder, pending register and state machine stay in irq_sequencer.

## Test plan
- Single source: reset, gie=1, irq_en=4'b0100. Raise irq_i[2]. Then pending[2]=1 after 3 edges. At the next pcflag with pc_resume=23'h000040: interrupt=1, isr_target=23'h000108. Next cycle: isr_return=23'h000040, irq_cause=2, in_isr=1, pending=0.
- Priority and tail-chain: raise irq_i[3] and irq_i[1] in the same cycle. Source 1 is taken first (target 23'h000104). MRET with pcflag, then the next pcflag takes source 3 (23'h00010C) with no idle boundary.
- Masking: gie=0 and irq_i[0] rises. pending[0]=1 and interrupt stays 0 across 10 pcflags. Set gie=1 and interrupt fires at the next pcflag.
- No nesting: while in_isr=1, raise irq_i[1]. interrupt stays 0 and pending[1]=1. After MRET, source 1 is taken.
- Set/clear collision: a second irq_i[0] edge reaches the detector on the acceptance edge of source 0. pending[0] remains 1 and source 0 is re-taken after MRET.
- Async reset while in_isr=1: in_isr=0, pending=0 and isr_return=0 immediately. A line held high during reset produces exactly one pending set afterwards.
